// File: rtl/led_matrix_pwm_driver.sv
// ============================================================================
// Module  : led_matrix_pwm_driver
// Brief   : Single-clock LED matrix scan driver with serial frame load,
//           tear-free frame swap, column blanking and per-pixel PWM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_matrix_pwm_driver #(
  parameter int unsigned NCOLS        = 8,
  parameter int unsigned NROWS        = 8,
  parameter int unsigned BPP          = 2,
  parameter int unsigned SLOT_LOG2    = 5,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             dclk,
  input  logic             strobe,
  output logic [NROWS-1:0] row_out,
  output logic [NCOLS-1:0] col_sel,
  output logic             frame_sync
);

  localparam int unsigned c_width = NCOLS * NROWS * BPP;
  localparam int unsigned c_col_w = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int unsigned c_pix_w = NROWS * BPP;
  localparam logic [c_col_w-1:0]   c_last_col = c_col_w'(NCOLS - 1);
  localparam logic [SLOT_LOG2-1:0] c_blank    = SLOT_LOG2'(BLANK_CYCLES);
  localparam logic [NCOLS-1:0]     c_col_one  = {{(NCOLS-1){1'b0}}, 1'b1};

  logic [1:0]             din_sync_q;
  logic [2:0]             dclk_sync_q;
  logic [2:0]             strobe_sync_q;

  logic [c_width-1:0]     chain_q,   chain_d;
  logic [c_width-1:0]     stage_q,   stage_d;
  logic [c_width-1:0]     disp_q,    disp_d;
  logic                   pending_q, pending_d;
  logic [SLOT_LOG2-1:0]   slot_q,    slot_d;
  logic [c_col_w-1:0]     col_q,     col_d;

  logic [NROWS-1:0]       row_out_q,    row_out_d;
  logic [NCOLS-1:0]       col_sel_q,    col_sel_d;
  logic                   frame_sync_q, frame_sync_d;

  logic                   w_dclk_rise;
  logic                   w_strobe_rise;
  logic                   w_slot_last;
  logic                   w_boundary;
  logic                   w_blank;
  logic [BPP-1:0]         w_phase;
  logic [c_pix_w-1:0]     w_col_pix;

  // Third stage of dclk/strobe is only the edge-detect reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_sync_q    <= '0;
      dclk_sync_q   <= '0;
      strobe_sync_q <= '0;
    end else begin
      din_sync_q    <= {din_sync_q[0], din};
      dclk_sync_q   <= {dclk_sync_q[1:0], dclk};
      strobe_sync_q <= {strobe_sync_q[1:0], strobe};
    end
  end

  assign w_dclk_rise   = dclk_sync_q[1] & ~dclk_sync_q[2];
  assign w_strobe_rise = strobe_sync_q[1] & ~strobe_sync_q[2];
  assign w_slot_last   = (slot_q == '1);
  assign w_boundary    = w_slot_last && (col_q == c_last_col);

  always_comb begin
    chain_d   = chain_q;
    stage_d   = stage_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    slot_d    = slot_q + 1'b1;
    col_d     = col_q;

    if (w_dclk_rise) begin
      chain_d = {chain_q[c_width-2:0], din_sync_q[1]};
    end
    // Stage samples the pre-shift chain; swap uses the pre-capture stage.
    if (w_strobe_rise) begin
      stage_d = chain_q;
    end
    if (w_boundary && pending_q) begin
      disp_d = stage_q;
    end
    if (w_strobe_rise) begin
      pending_d = 1'b1;
    end else if (w_boundary) begin
      pending_d = 1'b0;
    end

    if (w_slot_last) begin
      col_d = (col_q == c_last_col) ? '0 : col_q + 1'b1;
    end
  end

  assign w_blank   = (slot_q < c_blank);
  assign w_phase   = slot_q[SLOT_LOG2-1 -: BPP];
  assign w_col_pix = disp_q[int'(col_q) * c_pix_w +: c_pix_w];

  always_comb begin
    row_out_d    = '0;
    col_sel_d    = '0;
    frame_sync_d = (slot_q == '0) && (col_q == '0);
    if (!w_blank) begin
      col_sel_d = c_col_one << col_q;
      for (int r = 0; r < int'(NROWS); r++) begin
        row_out_d[r] = (w_col_pix[r*BPP +: BPP] > w_phase);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q      <= '0;
      stage_q      <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      slot_q       <= '0;
      col_q        <= '0;
      row_out_q    <= '0;
      col_sel_q    <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      chain_q      <= chain_d;
      stage_q      <= stage_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      slot_q       <= slot_d;
      col_q        <= col_d;
      row_out_q    <= row_out_d;
      col_sel_q    <= col_sel_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign row_out    = row_out_q;
  assign col_sel    = col_sel_q;
  assign frame_sync = frame_sync_q;

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_pwm_driver.sv
// ============================================================================
// Module  : tb_led_matrix_pwm_driver
// Brief   : Scoreboard bench for led_matrix_pwm_driver with a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_matrix_pwm_driver;

  localparam int NC    = 8;
  localparam int NR    = 8;
  localparam int BPP   = 2;
  localparam int SLOT  = 32;
  localparam int BLANK = 2;
  localparam int W     = NC * NR * BPP;
  localparam int FRAME = NC * SLOT;

  typedef struct {
    int edge_n;
    bit is_strobe;
    bit d;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [7:0] row;
    logic [7:0] cs;
    logic       fs;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       dclk;
  logic       strobe;
  logic [7:0] row_out;
  logic [7:0] col_sel;
  logic       frame_sync;

  ev_t          evq[$];
  exp_t         expq[$];
  logic [W-1:0] m_chain;
  logic [W-1:0] m_stage;
  logic [W-1:0] m_disp;
  bit           m_pending;
  int           e_cnt;
  int           total;
  int           bad;

  led_matrix_pwm_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dclk       (dclk),
    .strobe     (strobe),
    .row_out    (row_out),
    .col_sel    (col_sel),
    .frame_sync (frame_sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected display for scan cycle k: which column/slot it is, and whether
  // each pixel's grey level exceeds the PWM phase of that slot.
  function automatic exp_t expect_at(input int k, input logic [W-1:0] img);
    exp_t x;
    int   slot;
    int   col;
    int   phase;
    int   pix;
    slot  = k % SLOT;
    col   = (k / SLOT) % NC;
    phase = slot / (SLOT / (1 << BPP));
    x.cyc = k;
    x.fs  = (k % FRAME == 0);
    x.row = '0;
    x.cs  = '0;
    if (slot >= BLANK) begin
      x.cs = 8'd1 << col;
      for (int r = 0; r < NR; r++) begin
        pix      = int'(img[(col*NR + r)*BPP +: BPP]);
        x.row[r] = (pix > phase);
      end
    end
    return x;
  endfunction

  // Reference model: advances once per clk edge, predicts the output that
  // edge produces, then applies swap / capture / shift in that order.
  initial begin
    int  e;
    int  k;
    bit  do_s;
    bit  do_sh;
    bit  b;
    ev_t ev;
    e_cnt = 0;
    m_chain = '0; m_stage = '0; m_disp = '0; m_pending = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e_cnt = 0;
        m_chain = '0; m_stage = '0; m_disp = '0; m_pending = 0;
        evq.delete();
        expq.delete();
      end else begin
        e = e_cnt + 1;
        k = e_cnt;
        do_s = 0; do_sh = 0; b = 0;
        expq.push_back(expect_at(k, m_disp));
        if ((k % FRAME == FRAME - 1) && m_pending) begin
          m_disp    = m_stage;
          m_pending = 0;
        end
        while (evq.size() > 0 && evq[0].edge_n <= e) begin
          ev = evq.pop_front();
          if (ev.edge_n == e) begin
            if (ev.is_strobe) do_s = 1;
            else begin do_sh = 1; b = ev.d; end
          end
        end
        if (do_s) begin
          m_stage   = m_chain;
          m_pending = 1;
        end
        if (do_sh) m_chain = {m_chain[W-2:0], b};
        e_cnt = e;
      end
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && expq.size() > 0) begin
        x = expq.pop_front();
        total++;
        if (row_out !== x.row || col_sel !== x.cs || frame_sync !== x.fs) begin
          bad++;
          $display("FAIL scan cyc=%0d got row_out=%h col_sel=%h frame_sync=%b want row_out=%h col_sel=%h frame_sync=%b",
                   x.cyc, row_out, col_sel, frame_sync, x.row, x.cs, x.fs);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    total++;
    if (row_out !== 8'h00 || col_sel !== 8'h00 || frame_sync !== 1'b0) begin
      bad++;
      $display("FAIL %s got row_out=%h col_sel=%h frame_sync=%b want all zero",
               name, row_out, col_sel, frame_sync);
    end
  endtask

  // Pins change just after an edge and hold 3+ cycles per level; the effect
  // lands 3 clk edges after the pin rise.
  task automatic pulse(input bit dk, input bit st, input bit b);
    @(posedge clk); #1;
    din = b;
    if (st) begin
      strobe = 1'b1;
      evq.push_back('{e_cnt + 3, 1'b1, 1'b0});
    end
    if (dk) begin
      dclk = 1'b1;
      evq.push_back('{e_cnt + 3, 1'b0, b});
    end
    repeat (3) @(posedge clk);
    #1;
    dclk   = 1'b0;
    strobe = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic load_frame(input logic [W-1:0] f);
    for (int i = W - 1; i >= 0; i--) pulse(1'b1, 1'b0, f[i]);
  endtask

  task automatic wait_cyc(input int val);
    int n;
    n = 0;
    @(posedge clk); #1;
    while ((e_cnt % FRAME) != val && n < 2 * FRAME) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2 * FRAME) begin
      total++;
      bad++;
      $display("FAIL wait_timeout got cyc=%0d want phase=%0d", e_cnt, val);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got time=%0t want finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] f;
    total = 0; bad = 0;
    rst_n = 1'b0; din = 1'b0; dclk = 1'b0; strobe = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      din    = 1'($urandom);
      dclk   = ~dclk;
      strobe = ~strobe;
      #1 check_zero("reset_hold");
    end
    din = 1'b0; dclk = 1'b0; strobe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 40) @(posedge clk);

    load_frame('1);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2 * FRAME) @(posedge clk);

    load_frame({64{2'b01}});
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2 * FRAME) @(posedge clk);

    f = '0;
    f[(3*NR + 5)*BPP +: BPP] = 2'b11;
    load_frame(f);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2 * FRAME) @(posedge clk);

    // Tear-free: random frame A shown, random frame B strobed in column 4.
    load_frame({$urandom, $urandom, $urandom, $urandom});
    pulse(1'b0, 1'b1, 1'b0);
    repeat (FRAME) @(posedge clk);
    load_frame({$urandom, $urandom, $urandom, $urandom});
    wait_cyc(4 * SLOT + 5);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2 * FRAME) @(posedge clk);

    // Two strobes in one frame, the second coinciding with a shift.
    load_frame({$urandom, $urandom, $urandom, $urandom});
    wait_cyc(10);
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'($urandom));
    pulse(1'b1, 1'b1, 1'($urandom));
    repeat (2 * FRAME) @(posedge clk);

    // Strobe landing exactly on the boundary cycle with a frame pending.
    wait_cyc(20);
    for (int i = 0; i < 2; i++) pulse(1'b1, 1'b0, 1'($urandom));
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) pulse(1'b1, 1'b0, 1'($urandom));
    wait_cyc(FRAME - 4);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2 * FRAME) @(posedge clk);

    // Asynchronous reset in the middle of a frame.
    wait_cyc(3 * SLOT + 12);
    #2 rst_n = 1'b0;
    #1 check_zero("midframe_reset");
    @(negedge clk);
    check_zero("midframe_reset_hold");
    repeat (2) @(posedge clk);
    #1 check_zero("midframe_reset_hold2");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME + 10) @(posedge clk);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
